// File: rtl/abro_ctrl_pkg.sv
// ============================================================================
// abro_ctrl_pkg: shared FSM state encoding and default sizing for abro_seq_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package abro_ctrl_pkg;

    localparam int DEF_NSTEP   = 4;
    localparam int DEF_RST_CYC = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DUT_RST = 3'd1,
        S_DRIVE   = 3'd2,
        S_CHECK   = 3'd3,
        S_FINISH  = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/abro_ctrl_cnt.sv
// ============================================================================
// abro_ctrl_cnt: loadable up/down counter with terminal-count compare
// Rev 1.0
// ============================================================================
`default_nettype none

module abro_ctrl_cnt
    import abro_ctrl_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic [WIDTH-1:0] term_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            cnt_d = up_i ? (cnt_q + 1'b1) : (cnt_q - 1'b1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == term_i);

endmodule

`default_nettype wire

// File: rtl/abro_seq_ctrl.sv
// ============================================================================
// abro_seq_ctrl: resets an ABRO machine, plays a captured A/B sequence into it
// and checks its output step by step. Rev 1.0
// ============================================================================
`default_nettype none

module abro_seq_ctrl
    import abro_ctrl_pkg::*;
#(
    parameter int NSTEP   = DEF_NSTEP,
    parameter int RST_CYC = DEF_RST_CYC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2*NSTEP-1:0]       pat,
    input  logic [NSTEP-1:0]         exp_o,
    output logic                     dut_rst_n,
    output logic                     dut_a,
    output logic                     dut_b,
    input  logic                     dut_o,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [$clog2(NSTEP)-1:0] fail_step
);

    localparam int KW = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam int CW = (KW > RW) ? KW : RW;

    state_e                  state_q, state_d;
    logic [NSTEP-1:0][1:0]   pat_q;
    logic [NSTEP-1:0]        exp_q;
    logic                    cap_en;
    logic                    pass_q, pass_d;
    logic [KW-1:0]           fs_q, fs_d;
    logic                    dut_rst_n_q, dut_a_q, dut_b_q;
    logic                    dut_a_d, dut_b_d;

    logic                    cnt_load, cnt_en, cnt_up, cnt_tc;
    logic [CW-1:0]           cnt_term, cnt_val;
    logic [KW-1:0]           k, k_nxt;

    // One counter serves both phases: it counts the reset hold down to 0,
    // which leaves it at step index 0 for the first DRIVE.
    abro_ctrl_cnt #(
        .WIDTH (CW)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (CW'(RST_CYC - 1)),
        .en_i       (cnt_en),
        .up_i       (cnt_up),
        .term_i     (cnt_term),
        .cnt_o      (cnt_val),
        .tc_o       (cnt_tc)
    );

    assign k        = cnt_val[KW-1:0];
    assign cnt_up   = (state_q != S_DUT_RST);
    assign cnt_term = (state_q == S_DUT_RST) ? '0 : CW'(NSTEP - 1);
    assign k_nxt    = cnt_en ? (k + 1'b1) : k;

    always_comb begin
        state_d  = state_q;
        cap_en   = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        pass_d   = pass_q;
        fs_d     = fs_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cap_en   = 1'b1;
                    cnt_load = 1'b1;
                    pass_d   = 1'b0;
                    fs_d     = '0;
                    state_d  = S_DUT_RST;
                end
            end
            S_DUT_RST: begin
                if (cnt_tc) begin
                    state_d = S_DRIVE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_DRIVE: state_d = S_CHECK;
            S_CHECK: begin
                if (dut_o == exp_q[k]) begin
                    if (cnt_tc) begin
                        pass_d  = 1'b1;
                        state_d = S_FINISH;
                    end else begin
                        cnt_en  = 1'b1;
                        state_d = S_DRIVE;
                    end
                end else begin
                    fs_d    = k;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        dut_a_d = 1'b0;
        dut_b_d = 1'b0;
        if (state_d == S_DRIVE) begin
            dut_a_d = pat_q[k_nxt][1];
            dut_b_d = pat_q[k_nxt][0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pat_q       <= '0;
            exp_q       <= '0;
            pass_q      <= 1'b0;
            fs_q        <= '0;
            dut_rst_n_q <= 1'b0;
            dut_a_q     <= 1'b0;
            dut_b_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            fs_q        <= fs_d;
            dut_rst_n_q <= (state_d != S_DUT_RST);
            dut_a_q     <= dut_a_d;
            dut_b_q     <= dut_b_d;
            if (cap_en) begin
                pat_q <= pat;
                exp_q <= exp_o;
            end
        end
    end

    assign dut_rst_n = dut_rst_n_q;
    assign dut_a     = dut_a_q;
    assign dut_b     = dut_b_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign pass      = pass_q;
    assign fail_step = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_abro_seq_ctrl.sv
// ============================================================================
// tb_abro_seq_ctrl: directed scenarios for abro_seq_ctrl with an AND-register
// stand-in for the ABRO machine. Rev 1.0
// ============================================================================
`default_nettype none

module tb_abro_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pat = 8'h00;
    logic [3:0] exp_o = 4'h0;
    logic       dut_rst_n, dut_a, dut_b, dut_o;
    logic       busy, done, pass;
    logic [1:0] fail_step;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Stand-in DUT: output is the registered AND of its inputs.
    always_ff @(posedge clk or negedge dut_rst_n) begin
        if (!dut_rst_n) dut_o <= 1'b0;
        else            dut_o <= dut_a & dut_b;
    end

    abro_seq_ctrl #(.NSTEP(4), .RST_CYC(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pat       (pat),
        .exp_o     (exp_o),
        .dut_rst_n (dut_rst_n),
        .dut_a     (dut_a),
        .dut_b     (dut_b),
        .dut_o     (dut_o),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_step (fail_step)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [7:0] p, input logic [3:0] e);
        @(negedge clk);
        pat = p; exp_o = e; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        total++; if ({dut_rst_n, dut_a, dut_b, busy, done, pass, fail_step} !== 8'b0) begin
            bad++;
            $display("FAIL reset_async got=%b want=00000000", {dut_rst_n, dut_a, dut_b, busy, done, pass, fail_step});
        end
        tick(); tick();
        total++; if ({dut_rst_n, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_held got=%b want=000", {dut_rst_n, busy, done});
        end
        @(negedge clk); rst = 1'b0;
        tick();
        total++; if (dut_rst_n !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_rstn got=%b want=1", dut_rst_n);
        end
        total++; if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_pass();
        logic [7:0] pv;
        logic ea, eb;
        pv = 8'hE4;
        kick(pv, 4'b1000);
        for (int c = 1; c <= 12; c++) begin
            ea = 1'b0; eb = 1'b0;
            if (c >= 3 && c <= 9 && (c % 2) == 1) begin
                ea = pv[c-2];
                eb = pv[c-3];
            end
            total++; if (dut_rst_n !== (c > 2)) begin
                bad++;
                $display("FAIL pass_rstn c=%0d got=%b want=%b", c, dut_rst_n, c > 2);
            end
            total++; if (done !== (c == 11)) begin
                bad++;
                $display("FAIL pass_done c=%0d got=%b want=%b", c, done, c == 11);
            end
            total++; if (busy !== (c <= 11)) begin
                bad++;
                $display("FAIL pass_busy c=%0d got=%b want=%b", c, busy, c <= 11);
            end
            total++; if ({dut_a, dut_b} !== {ea, eb}) begin
                bad++;
                $display("FAIL pass_ab c=%0d got=%b%b want=%b%b", c, dut_a, dut_b, ea, eb);
            end
            if (c == 11) begin
                total++; if ({pass, fail_step} !== 3'b100) begin
                    bad++;
                    $display("FAIL pass_result got=%b/%0d want=1/0", pass, fail_step);
                end
            end
            tick();
        end
    endtask

    task automatic test_fail(input logic [3:0] ev, input int dc, input logic [1:0] fs);
        kick(8'hE4, ev);
        for (int c = 1; c <= dc + 2; c++) begin
            total++; if (done !== (c == dc)) begin
                bad++;
                $display("FAIL fail_done exp=%b c=%0d got=%b want=%b", ev, c, done, c == dc);
            end
            total++; if (busy !== (c <= dc)) begin
                bad++;
                $display("FAIL fail_busy exp=%b c=%0d got=%b want=%b", ev, c, busy, c <= dc);
            end
            if (c >= dc - 1) begin
                total++; if ({dut_a, dut_b} !== 2'b00) begin
                    bad++;
                    $display("FAIL fail_ab_idle exp=%b c=%0d got=%b%b want=00", ev, c, dut_a, dut_b);
                end
            end
            if (c == dc || c == dc + 2) begin
                total++; if ({pass, fail_step} !== {1'b0, fs}) begin
                    bad++;
                    $display("FAIL fail_result exp=%b c=%0d got=%b/%0d want=0/%0d", ev, c, pass, fail_step, fs);
                end
            end
            tick();
        end
    endtask

    task automatic test_ignore_start();
        kick(8'hE4, 4'b1000);
        for (int c = 1; c <= 13; c++) begin
            total++; if (done !== (c == 11)) begin
                bad++;
                $display("FAIL ign_done c=%0d got=%b want=%b", c, done, c == 11);
            end
            total++; if (busy !== (c <= 11)) begin
                bad++;
                $display("FAIL ign_busy c=%0d got=%b want=%b", c, busy, c <= 11);
            end
            if (c == 9) begin
                total++; if ({dut_a, dut_b} !== 2'b11) begin
                    bad++;
                    $display("FAIL ign_captured_ab got=%b%b want=11", dut_a, dut_b);
                end
            end
            if (c == 11) begin
                total++; if (pass !== 1'b1) begin
                    bad++;
                    $display("FAIL ign_pass got=%b want=1", pass);
                end
            end
            start = (c == 3 || c == 11);
            if (c == 4) pat = 8'h00;
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_rst_midrun();
        kick(8'hE4, 4'b1000);
        for (int c = 1; c < 7; c++) tick();
        total++; if ({dut_a, dut_b} !== 2'b10) begin
            bad++;
            $display("FAIL mid_pre_ab got=%b%b want=10", dut_a, dut_b);
        end
        #2 rst = 1'b1;
        #1;
        total++; if ({dut_rst_n, dut_a, dut_b, busy, done, pass, fail_step} !== 8'b0) begin
            bad++;
            $display("FAIL mid_async got=%b want=00000000", {dut_rst_n, dut_a, dut_b, busy, done, pass, fail_step});
        end
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            total++; if ({dut_rst_n, busy, done} !== 3'b100) begin
                bad++;
                $display("FAIL mid_after c=%0d got=%b want=100", c, {dut_rst_n, busy, done});
            end
        end
    endtask

    task automatic test_back_to_back();
        kick(8'hE4, 4'b1000);
        for (int c = 1; c <= 24; c++) begin
            total++; if (done !== (c == 11 || c == 23)) begin
                bad++;
                $display("FAIL b2b_done c=%0d got=%b want=%b", c, done, c == 11 || c == 23);
            end
            if (c == 12) begin
                total++; if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_busy12 got=%b want=0", busy);
                end
            end
            if (c == 13) begin
                total++; if ({busy, pass} !== 2'b10) begin
                    bad++;
                    $display("FAIL b2b_clear got=%b want=10", {busy, pass});
                end
            end
            if (c == 23) begin
                total++; if (pass !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_pass got=%b want=1", pass);
                end
            end
            start = (c == 12);
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail(4'b1010, 7, 2'd1);
        test_fail(4'b1001, 5, 2'd0);
        test_fail(4'b0000, 11, 2'd3);
        test_ignore_start();
        test_rst_midrun();
        test_pass();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/abro_seq_ctrl.md
ABRO_SEQ_CTRL -- requirements
Module: abro_seq_ctrl

Interface
REQ-001 Parameter NSTEP, default 4: number of stimulus steps per run.
REQ-002 Parameter RST_CYC, default 2: cycles the DUT reset is held low at run start.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  run request; sampled only in IDLE.
REQ-006 pat  in  2*NSTEP  stimulus; step k: pat[2k+1]=A, pat[2k]=B.
REQ-007 exp_o  in  NSTEP  expected DUT output after step k = exp_o[k].
REQ-008 dut_rst_n  out  1  active-low reset to the ABRO machine.
REQ-009 dut_a, dut_b  out  1 each  registered A/B inputs to the ABRO machine.
REQ-010 dut_o  in  1  ABRO output O.
REQ-011 busy  out  1  high whenever state != IDLE.
REQ-012 done  out  1  one-cycle pulse at run end.
REQ-013 pass  out  1  run result; valid from done, held until next accepted start.
REQ-014 fail_step  out  $clog2(NSTEP)  index of first mismatching step; 0 on pass.

Function
REQ-015 FSM states: IDLE, DUT_RST, DRIVE, CHECK, FINISH.
REQ-016 IDLE: start=1 -> capture pat and exp_o into internal registers, clear pass/fail_step, go to DUT_RST; later changes to pat/exp_o shall not affect the run.
REQ-017 DUT_RST: dut_rst_n=0 for exactly RST_CYC cycles, then DRIVE with step index k=0.
REQ-018 DRIVE (1 cycle): dut_a/dut_b = captured step-k values; otherwise both 0.
REQ-019 CHECK (1 cycle): dut_o compared to exp_o[k] at end of cycle; match and k<NSTEP-1 -> k+1, DRIVE; match and k=NSTEP-1 -> FINISH with pass=1.
REQ-020 Mismatch in CHECK: go to FINISH immediately, pass=0, fail_step=k; remaining steps not driven.
REQ-021 FINISH (1 cycle): done=1, then IDLE; dut_rst_n=1 retained so DUT state stays observable.
REQ-022 Latency: full passing run asserts done exactly RST_CYC+2*NSTEP+1 cycles after the start-sampling edge (11 with defaults); failure at step k: RST_CYC+2*(k+1)+1.
REQ-023 start outside IDLE (including FINISH cycle) ignored; start in cycle after done accepted.
REQ-024 Step index wraps never; counter width $clog2(NSTEP), terminal compare against NSTEP-1.

Reset
REQ-025 rst=1 forces asynchronously: state IDLE, dut_rst_n=0, dut_a=dut_b=0, busy=0, done=0, pass=0, fail_step=0, k=0.
REQ-026 After rst release, dut_rst_n=1 from first clock edge in IDLE.
REQ-027 rst mid-run aborts without done; next run requires fresh start.

Structure
REQ-028 Package abro_ctrl_pkg holds the FSM state enum and default NSTEP/RST_CYC constants.
REQ-029 Sub-module abro_ctrl_cnt: loadable down/up counter used for DUT_RST duration and step index, with terminal-count flag.

Verification (bench stub: dut_o = registered dut_a & dut_b)
REQ-030 pat=8'hE4, exp_o=4'b1000, start -> dut_rst_n low cycles 1-2, done at cycle 11, pass=1, fail_step=0.
REQ-031 pat=8'hE4, exp_o=4'b1010 -> done at cycle 7, pass=0, fail_step=1, dut_a/dut_b 0 after step 1.
REQ-032 start pulsed again at cycles 3 and 11 (FINISH), pat changed to 8'h00 at cycle 4 -> single run, result as REQ-030, busy low at cycle 12.
REQ-033 rst asserted during step 2 DRIVE -> same-cycle outputs per REQ-025, no done pulse; subsequent start runs normally.
REQ-034 start at cycle 12 after a pass -> pass cleared at cycle 13, second run completes done at cycle 23.
